// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Purpose:
//   Shares the register file's single write port between two requesters.
//     A - pipeline writeback. It is always accepted and always has priority.
//     B - a multi-cycle unit (mul/div/load-miss). It uses valid/ready and is
//         buffered in a small FIFO that drains whenever A leaves the port idle.
//   A starvation counter raises stall_req so the hazard unit can bubble WB and
//   let the FIFO drain.
//
// Handshake:
//   A B request transfers in a cycle where b_valid && b_ready. b_ready depends
//   only on registered state (FIFO not full) and on rst_n. It never depends
//   on b_valid. A has no ready signal and is never back-pressured.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid, a_rd, a_data      writeback write request
//   b_valid, b_ready           multi-cycle unit handshake
//   b_rd, b_data               multi-cycle unit write request
//   rf_we, rf_waddr, rf_wdata  registered register-file write port
//   stall_req                  registered request to bubble WB
//   fifo_count                 current FIFO occupancy
//   pending_mask               (RF_ARB_PENDING_EN only) registers that have
//                              queued B writes
//
// Configuration:
//   RF_ARB_PENDING_EN - when defined, adds the pending_mask output.
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     a_valid,
   input  logic [ADDR_W-1:0]        a_rd,
   input  logic [DATA_W-1:0]        a_data,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [ADDR_W-1:0]        b_rd,
   input  logic [DATA_W-1:0]        b_data,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   output logic                     stall_req,
`ifdef RF_ARB_PENDING_EN
   output logic [2**ADDR_W-1:0]     pending_mask,
`endif
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   // FIFO storage (no reset needed; validity is tracked by count_q)
   logic [ADDR_W-1:0] mem_rd_q   [DEPTH];
   logic [DATA_W-1:0] mem_data_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic              stall_q, stall_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

   logic full, empty, grant_a, pop, push;

   always_comb begin
      full    = (count_q == CNT_W'(DEPTH));
      empty   = (count_q == '0);
      b_ready = rst_n && !full;
      // A write to register 0 is dropped and does not hold the port.
      grant_a = a_valid && (a_rd != '0);
      pop     = !grant_a && !empty;
      // A B write to register 0 completes the handshake but is not stored.
      push    = b_valid && b_ready && (b_rd != '0);
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // The counter counts only the cycles in which the FIFO head loses to A.
      starve_d = starve_q;
      if (pop || empty)
         starve_d = '0;
      else if (grant_a && (starve_q != STV_W'(STARVE_LIMIT)))
         starve_d = starve_q + STV_W'(1);

      // A pop takes precedence. stall_req drops in the cycle after the head drains.
      stall_d = stall_q;
      if (pop)
         stall_d = 1'b0;
      else if (starve_q == STV_W'(STARVE_LIMIT))
         stall_d = 1'b1;

      rf_we_d    = grant_a || pop;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (grant_a) begin
         rf_waddr_d = a_rd;
         rf_wdata_d = a_data;
      end else if (pop) begin
         rf_waddr_d = mem_rd_q[rd_ptr_q];
         rf_wdata_d = mem_data_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         stall_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         stall_q    <= stall_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd_q[wr_ptr_q]   <= b_rd;
         mem_data_q[wr_ptr_q] <= b_data;
      end
   end

   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign stall_req  = stall_q;
   assign fifo_count = count_q;

`ifdef RF_ARB_PENDING_EN
   // Walks the occupied slots starting at the head. count_q is cleared by
   // reset, so the mask is zero during reset.
   logic [PTR_W-1:0] pend_idx;
   always_comb begin
      pending_mask = '0;
      pend_idx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_idx = rd_ptr_q + PTR_W'(i);
         if (CNT_W'(i) < count_q)
            pending_mask[mem_rd_q[pend_idx]] = 1'b1;
      end
      pending_mask[0] = 1'b0;
   end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed testbench for rf_write_arbiter. Inputs change 1 ns after each
// rising edge, and outputs are sampled at that same point. Each test task
// checks its own expected values.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              a_valid;
   logic [ADDR_W-1:0] a_rd;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_rd;
   logic [DATA_W-1:0] b_data;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              stall_req;
   logic [CNT_W-1:0]  fifo_count;
`ifdef RF_ARB_PENDING_EN
   logic [2**ADDR_W-1:0] pending_mask;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Expected register/data pairs, in the order they should leave the FIFO.
   logic [ADDR_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_d[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   rf_write_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_valid    (a_valid),
      .a_rd       (a_rd),
      .a_data     (a_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_rd       (b_rd),
      .b_data     (b_data),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .stall_req  (stall_req),
`ifdef RF_ARB_PENDING_EN
      .pending_mask(pending_mask),
`endif
      .fifo_count (fifo_count)
   );

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      step();
      tests_run++; if (b_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_b_ready got=%0b exp=0", b_ready); end
      tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
      tests_run++; if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
      tests_run++; if (stall_req !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
      tests_run++; if (rf_waddr !== '0) begin tests_failed++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
      #3 rst_n = 1'b1;
      #1;
      tests_run++; if (b_ready !== 1'b1) begin tests_failed++; $display("FAIL release_b_ready got=%0b exp=1", b_ready); end
      // Build some state, then reset in the middle of a cycle.
      step();
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h55;
      b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
      step();
      idle_inputs();
      tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("FAIL prereset_rf_we got=%0b exp=1", rf_we); end
      tests_run++; if (fifo_count !== 3'd1) begin tests_failed++; $display("FAIL prereset_count got=%0d exp=1", fifo_count); end
      #3 rst_n = 1'b0;
      #1;
      tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL async_rf_we got=%0b exp=0", rf_we); end
      tests_run++; if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL async_count got=%0d exp=0", fifo_count); end
      tests_run++; if (b_ready !== 1'b0) begin tests_failed++; $display("FAIL async_b_ready got=%0b exp=0", b_ready); end
      tests_run++; if (stall_req !== 1'b0) begin tests_failed++; $display("FAIL async_stall got=%0b exp=0", stall_req); end
      #1 rst_n = 1'b1;
      #1;
      tests_run++; if (b_ready !== 1'b1) begin tests_failed++; $display("FAIL rerelease_b_ready got=%0b exp=1", b_ready); end
   endtask

   task automatic test_a_only();
      step();
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
      step();
      idle_inputs();
      tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("FAIL a_only_we got=%0b exp=1", rf_we); end
      tests_run++; if (rf_waddr !== 5'd5) begin tests_failed++; $display("FAIL a_only_waddr got=%0d exp=5", rf_waddr); end
      tests_run++; if (rf_wdata !== 32'h1234) begin tests_failed++; $display("FAIL a_only_wdata got=%h exp=1234", rf_wdata); end
      step();
      tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL a_only_we_off got=%0b exp=0", rf_we); end
      tests_run++; if (rf_waddr !== 5'd5) begin tests_failed++; $display("FAIL a_only_hold_addr got=%0d exp=5", rf_waddr); end
      tests_run++; if (rf_wdata !== 32'h1234) begin tests_failed++; $display("FAIL a_only_hold_data got=%h exp=1234", rf_wdata); end
   endtask

   task automatic test_starvation();
      a_valid = 1'b1; a_rd = 5'd2; a_data = 32'hA2;
      for (int k = 0; k < 4; k++) begin
         b_valid = 1'b1; b_rd = ADDR_W'(7 + k); b_data = DATA_W'(k + 1);
         exp_q.push_back(ADDR_W'(7 + k));
         exp_d.push_back(DATA_W'(k + 1));
         step();
      end
      b_valid = 1'b0;
      tests_run++; if (b_ready !== 1'b0) begin tests_failed++; $display("FAIL starve_full_ready got=%0b exp=0", b_ready); end
      tests_run++; if (fifo_count !== 3'd4) begin tests_failed++; $display("FAIL starve_count got=%0d exp=4", fifo_count); end
      tests_run++; if (rf_waddr !== 5'd2) begin tests_failed++; $display("FAIL starve_a_addr got=%0d exp=2", rf_waddr); end
      // Three losses have been counted so far. After five more, the counter
      // reaches 8, and stall_req rises one cycle later.
      repeat (5) step();
      tests_run++; if (stall_req !== 1'b0) begin tests_failed++; $display("FAIL starve_early_stall got=%0b exp=0", stall_req); end
      step();
      tests_run++; if (stall_req !== 1'b1) begin tests_failed++; $display("FAIL starve_stall got=%0b exp=1", stall_req); end
      a_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         logic [ADDR_W-1:0] ea;
         logic [DATA_W-1:0] ed;
         step();
         ea = exp_q.pop_front();
         ed = exp_d.pop_front();
         tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("FAIL drain_we[%0d] got=%0b exp=1", k, rf_we); end
         tests_run++; if (rf_waddr !== ea) begin tests_failed++; $display("FAIL drain_addr[%0d] got=%0d exp=%0d", k, rf_waddr, ea); end
         tests_run++; if (rf_wdata !== ed) begin tests_failed++; $display("FAIL drain_data[%0d] got=%h exp=%h", k, rf_wdata, ed); end
         if (k == 0) begin
            tests_run++; if (stall_req !== 1'b0) begin tests_failed++; $display("FAIL drain_stall_clear got=%0b exp=0", stall_req); end
         end
      end
      step();
      tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL drain_idle_we got=%0b exp=0", rf_we); end
      tests_run++; if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL drain_count got=%0d exp=0", fifo_count); end
   endtask

   task automatic test_zero_reg();
      b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
      step();
      b_valid = 1'b0;
      a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hDEAD;
      step();
      a_valid = 1'b0;
      tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("FAIL zero_a_we got=%0b exp=1", rf_we); end
      tests_run++; if (rf_waddr !== 5'd7) begin tests_failed++; $display("FAIL zero_a_addr got=%0d exp=7", rf_waddr); end
      tests_run++; if (rf_wdata !== 32'h77) begin tests_failed++; $display("FAIL zero_a_data got=%h exp=77", rf_wdata); end
      b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hBEEF;
      #1;
      tests_run++; if (b_ready !== 1'b1) begin tests_failed++; $display("FAIL zero_b_ready got=%0b exp=1", b_ready); end
      step();
      b_valid = 1'b0;
      tests_run++; if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL zero_b_count got=%0d exp=0", fifo_count); end
      step();
      tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL zero_b_we got=%0b exp=0", rf_we); end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] d0, d1;
      d0 = DATA_W'($urandom_range(1, 32'hFFFF));
      d1 = DATA_W'($urandom_range(1, 32'hFFFF));
      b_valid = 1'b1; b_rd = 5'd4; b_data = d0;
      step();
      tests_run++; if (fifo_count !== 3'd1) begin tests_failed++; $display("FAIL b2b_count1 got=%0d exp=1", fifo_count); end
      b_rd = 5'd6; b_data = d1;
      step();
      b_valid = 1'b0;
      tests_run++; if (fifo_count !== 3'd1) begin tests_failed++; $display("FAIL b2b_pushpop_count got=%0d exp=1", fifo_count); end
      tests_run++; if (rf_waddr !== 5'd4 || rf_wdata !== d0) begin tests_failed++; $display("FAIL b2b_first got=%0d/%h exp=4/%h", rf_waddr, rf_wdata, d0); end
      step();
      tests_run++; if (rf_waddr !== 5'd6 || rf_wdata !== d1 || rf_we !== 1'b1) begin tests_failed++; $display("FAIL b2b_second got=%0d/%h we=%0b exp=6/%h we=1", rf_waddr, rf_wdata, rf_we, d1); end
      tests_run++; if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL b2b_count0 got=%0d exp=0", fifo_count); end
      step();
   endtask

   task automatic test_reset_mid_drain();
      a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
      for (int k = 0; k < 3; k++) begin
         b_valid = 1'b1; b_rd = ADDR_W'(11 + k); b_data = DATA_W'(k);
         step();
      end
      idle_inputs();
      tests_run++; if (fifo_count !== 3'd3) begin tests_failed++; $display("FAIL mid_count3 got=%0d exp=3", fifo_count); end
      #3 rst_n = 1'b0;
      #1;
      tests_run++; if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL mid_count0 got=%0d exp=0", fifo_count); end
      #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL mid_no_write[%0d] got=%0b exp=0", k, rf_we); end
      end
   endtask

`ifdef RF_ARB_PENDING_EN
   task automatic test_pending();
      logic [ADDR_W-1:0] rds [3];
      rds[0] = 5'd9; rds[1] = 5'd9; rds[2] = 5'd3;
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1;
      for (int k = 0; k < 3; k++) begin
         b_valid = 1'b1; b_rd = rds[k]; b_data = DATA_W'(k);
         step();
      end
      idle_inputs();
      tests_run++; if (pending_mask !== 32'h0000_0208) begin tests_failed++; $display("FAIL pend_full got=%h exp=00000208", pending_mask); end
      step();
      step();
      tests_run++; if (pending_mask !== 32'h0000_0008) begin tests_failed++; $display("FAIL pend_two_pops got=%h exp=00000008", pending_mask); end
      step();
      tests_run++; if (pending_mask !== 32'h0) begin tests_failed++; $display("FAIL pend_empty got=%h exp=0", pending_mask); end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_a_only();
      test_starvation();
      test_zero_reg();
      test_back_to_back();
      test_reset_mid_drain();
`ifdef RF_ARB_PENDING_EN
      test_pending();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
